// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM for the MIPS subset datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB over a shared, possibly stalling memory.
// Stuck accesses time out into HALT with a sticky bus_err.
// The counter `retired` counts completed instructions.
// Optional feature: define MULTICYCLE_LWRR_EN to decode op 6'b110100 as lwrr.
module multicycle_ctrl #(
  parameter int ALUCTL_W = 3,
  parameter int TIMEOUT  = 15,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          op,
  input  logic [5:0]          func,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                i_or_d,
  output logic                ir_we,
  output logic                pc_we,
  output logic [1:0]          pc_src,
  output logic                reg_we,
  output logic [1:0]          reg_dst,
  output logic [1:0]          wd_sel,
  output logic                alu_src_b,
  output logic                sign_ext,
  output logic [ALUCTL_W-1:0] alu_ctl,
  output logic                lwrr,
  output logic                illegal,
  output logic                bus_err,
  output logic [CNT_W-1:0]    retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_MEM    = 4'd3,
    S_WB_ALU = 4'd4,
    S_WB_MEM = 4'd5,
    S_BRANCH = 4'd6,
    S_JUMP   = 4'd7,
    S_HALT   = 4'd8
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_NOP   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_OR    = 6'h25;

  localparam logic [ALUCTL_W-1:0] ALU_ADD = '0;
  localparam logic [ALUCTL_W-1:0] ALU_SUB = ALUCTL_W'(1);
  localparam logic [ALUCTL_W-1:0] ALU_OR  = ALUCTL_W'(3);
  localparam logic [ALUCTL_W-1:0] ALU_LUI = ALUCTL_W'(4);

  // TIMEOUT is limited to 1..255, so an 8-bit wait counter always suffices.
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  state_t     state, state_next;
  logic [7:0] wait_cnt;
  logic       timeout_hit;

  logic is_ralu, is_ori, is_lui, is_lw, is_sw, is_beq;
  logic is_j, is_jal, is_jr, is_nop, is_lwrr, is_load, go_exec;

  assign is_ralu = (op == OP_RTYPE) &&
                   ((func == FN_ADDU) || (func == FN_SUBU) || (func == FN_OR));
  assign is_nop  = (op == OP_RTYPE) && (func == FN_NOP);
  assign is_jr   = (op == OP_RTYPE) && (func == FN_JR);
  assign is_ori  = (op == OP_ORI);
  assign is_lui  = (op == OP_LUI);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_beq  = (op == OP_BEQ);
  assign is_j    = (op == OP_J);
  assign is_jal  = (op == OP_JAL);
`ifdef MULTICYCLE_LWRR_EN
  localparam logic [5:0] OP_LWRR = 6'h34;
  assign is_lwrr = (op == OP_LWRR);
`else
  assign is_lwrr = 1'b0;
`endif
  assign is_load = is_lw | is_lwrr;
  assign go_exec = is_ralu | is_ori | is_lui | is_load | is_sw;

  // State register; reset lands in FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  // Next state and datapath controls; everything forced low while in reset.
  always_comb begin
    state_next  = state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    i_or_d      = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_src      = 2'd0;
    reg_we      = 1'b0;
    reg_dst     = 2'd0;
    wd_sel      = 2'd0;
    alu_src_b   = 1'b0;
    sign_ext    = 1'b0;
    alu_ctl     = ALU_ADD;
    lwrr        = 1'b0;
    illegal     = 1'b0;
    timeout_hit = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we      = 1'b1;
            pc_we      = 1'b1;
            state_next = S_DECODE;
          end else if (wait_cnt == TO_LIM) begin
            timeout_hit = 1'b1;
            state_next  = S_HALT;
          end
        end
        S_DECODE: begin
          lwrr = is_lwrr;
          if (go_exec)                     state_next = S_EXEC;
          else if (is_beq)                 state_next = S_BRANCH;
          else if (is_j | is_jal | is_jr)  state_next = S_JUMP;
          else begin
            illegal    = ~is_nop;
            state_next = S_FETCH;
          end
        end
        S_EXEC: begin
          lwrr = is_lwrr;
          if (is_load | is_sw) begin
            alu_src_b  = 1'b1;
            sign_ext   = 1'b1;
            state_next = S_MEM;
          end else if (is_ralu) begin
            alu_ctl    = (func == FN_SUBU) ? ALU_SUB :
                         (func == FN_OR)   ? ALU_OR  : ALU_ADD;
            state_next = S_WB_ALU;
          end else if (is_ori) begin
            alu_src_b  = 1'b1;
            alu_ctl    = ALU_OR;
            state_next = S_WB_ALU;
          end else if (is_lui) begin
            alu_src_b  = 1'b1;
            alu_ctl    = ALU_LUI;
            state_next = S_WB_ALU;
          end else begin
            state_next = S_FETCH;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          i_or_d  = 1'b1;
          mem_we  = is_sw;
          lwrr    = is_lwrr;
          if (mem_ready) begin
            state_next = is_sw ? S_FETCH : S_WB_MEM;
          end else if (wait_cnt == TO_LIM) begin
            timeout_hit = 1'b1;
            state_next  = S_HALT;
          end
        end
        S_WB_ALU: begin
          reg_we     = 1'b1;
          reg_dst    = is_ralu ? 2'd1 : 2'd0;
          state_next = S_FETCH;
        end
        S_WB_MEM: begin
          reg_we     = 1'b1;
          wd_sel     = 2'd1;
          lwrr       = is_lwrr;
          state_next = S_FETCH;
        end
        S_BRANCH: begin
          alu_ctl    = ALU_SUB;
          pc_we      = zero;
          pc_src     = 2'd1;
          state_next = S_FETCH;
        end
        S_JUMP: begin
          pc_we  = 1'b1;
          pc_src = is_jr ? 2'd3 : 2'd2;
          if (is_jal) begin
            reg_we  = 1'b1;
            reg_dst = 2'd2;
            wd_sel  = 2'd2;
          end
          state_next = S_FETCH;
        end
        S_HALT:  state_next = S_HALT;
        default: state_next = S_FETCH;
      endcase
    end
  end

  // Retire counter, sticky bus error and per-access wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired  <= '0;
      bus_err  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      if ((state != S_FETCH) && (state_next == S_FETCH))
        retired <= retired + CNT_W'(1);
      if (timeout_hit)
        bus_err <= 1'b1;
      if (state_next != state)
        wait_cnt <= '0;
      else if (mem_req && !mem_ready && (wait_cnt != TO_LIM))
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: queue of per-cycle stimulus and expected outputs.
module tb_multicycle_ctrl;
  localparam int ALUCTL_W = 3;
  localparam int TIMEOUT  = 4;
  localparam int CNT_W    = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] op = '0, func = '0;
  logic zero = 1'b0, mem_ready = 1'b0;
  logic mem_req, mem_we, i_or_d, ir_we, pc_we, reg_we, alu_src_b, sign_ext;
  logic lwrr, illegal, bus_err;
  logic [1:0] pc_src, reg_dst, wd_sel;
  logic [ALUCTL_W-1:0] alu_ctl;
  logic [CNT_W-1:0] retired;

  multicycle_ctrl #(.ALUCTL_W(ALUCTL_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .func(func), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
    .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_src_b(alu_src_b),
    .sign_ext(sign_ext), .alu_ctl(alu_ctl), .lwrr(lwrr), .illegal(illegal),
    .bus_err(bus_err), .retired(retired)
  );

  always #5 clk = ~clk;

  logic [18:0] act;
  assign act = {mem_req, mem_we, i_or_d, ir_we, pc_we, pc_src, reg_we, reg_dst,
                wd_sel, alu_src_b, sign_ext, alu_ctl, lwrr, illegal};

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  func;
    logic        zero;
    logic        rdy;
    logic [18:0] exp;
    logic        ret;
    logic        err;
  } cyc_t;

  cyc_t q[$];
  int nchk = 0, nerr = 0;
  logic [CNT_W-1:0] mret = '0;
  logic             merr = 1'b0;

  typedef enum int {C_RALU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_JR,
                    C_NOP, C_ILL, C_LWRR} cls_t;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, a, e, $time);
    end
  endtask

  function automatic logic [18:0] pk(input logic mreq, mwe, iod, irwe, pcwe,
      input logic [1:0] psrc, input logic rwe, input logic [1:0] rdst, wsel,
      input logic bsrc, sext, input logic [2:0] alu, input logic lwf, ill);
    return {mreq, mwe, iod, irwe, pcwe, psrc, rwe, rdst, wsel, bsrc, sext, alu, lwf, ill};
  endfunction

  function automatic cls_t classify(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'h00: case (f)
               6'h21, 6'h23, 6'h25: return C_RALU;
               6'h08: return C_JR;
               6'h00: return C_NOP;
               default: return C_ILL;
             endcase
      6'h02: return C_J;
      6'h03: return C_JAL;
      6'h04: return C_BEQ;
      6'h0D: return C_ORI;
      6'h0F: return C_LUI;
      6'h23: return C_LW;
      6'h2B: return C_SW;
`ifdef MULTICYCLE_LWRR_EN
      6'h34: return C_LWRR;
`endif
      default: return C_ILL;
    endcase
  endfunction

  task automatic push(input logic [5:0] o, f, input logic z, r,
                      input logic [18:0] e, input logic ret, err);
    cyc_t c;
    c.op = o; c.func = f; c.zero = z; c.rdy = r; c.exp = e; c.ret = ret; c.err = err;
    q.push_back(c);
  endtask

  // Expected cycle trace of one instruction: fw fetch waits, mw memory waits.
  task automatic add_instr(input logic [5:0] o, f, input int fw, mw, input logic z);
    cls_t c = classify(o, f);
    logic lwf = (c == C_LWRR);
    logic [2:0] ralu = (f == 6'h23) ? 3'd1 : (f == 6'h25) ? 3'd3 : 3'd0;
    for (int i = 0; i < fw; i++)
      push(o, f, z, 1'b0, pk(1,0,0,0,0,2'd0,0,2'd0,2'd0,0,0,3'd0,0,0), 0, 0);
    push(o, f, z, 1'b1, pk(1,0,0,1,1,2'd0,0,2'd0,2'd0,0,0,3'd0,0,0), 0, 0);
    push(o, f, z, 1'b1, pk(0,0,0,0,0,2'd0,0,2'd0,2'd0,0,0,3'd0,lwf,c == C_ILL),
         (c == C_NOP) || (c == C_ILL), 0);
    case (c)
      C_RALU: begin
        push(o, f, z, 1'b1, pk(0,0,0,0,0,2'd0,0,2'd0,2'd0,0,0,ralu,0,0), 0, 0);
        push(o, f, z, 1'b1, pk(0,0,0,0,0,2'd0,1,2'd1,2'd0,0,0,3'd0,0,0), 1, 0);
      end
      C_ORI, C_LUI: begin
        push(o, f, z, 1'b1, pk(0,0,0,0,0,2'd0,0,2'd0,2'd0,1,0,
                               (c == C_ORI) ? 3'd3 : 3'd4,0,0), 0, 0);
        push(o, f, z, 1'b1, pk(0,0,0,0,0,2'd0,1,2'd0,2'd0,0,0,3'd0,0,0), 1, 0);
      end
      C_LW, C_LWRR, C_SW: begin
        logic st = (c == C_SW);
        push(o, f, z, 1'b1, pk(0,0,0,0,0,2'd0,0,2'd0,2'd0,1,1,3'd0,lwf,0), 0, 0);
        for (int i = 0; i < mw; i++)
          push(o, f, z, 1'b0, pk(1,st,1,0,0,2'd0,0,2'd0,2'd0,0,0,3'd0,lwf,0), 0, 0);
        push(o, f, z, 1'b1, pk(1,st,1,0,0,2'd0,0,2'd0,2'd0,0,0,3'd0,lwf,0), st, 0);
        if (!st)
          push(o, f, z, 1'b1, pk(0,0,0,0,0,2'd0,1,2'd0,2'd1,0,0,3'd0,lwf,0), 1, 0);
      end
      C_BEQ:
        push(o, f, z, 1'b1, pk(0,0,0,0,z,2'd1,0,2'd0,2'd0,0,0,3'd1,0,0), 1, 0);
      C_J:
        push(o, f, z, 1'b1, pk(0,0,0,0,1,2'd2,0,2'd0,2'd0,0,0,3'd0,0,0), 1, 0);
      C_JAL:
        push(o, f, z, 1'b1, pk(0,0,0,0,1,2'd2,1,2'd2,2'd2,0,0,3'd0,0,0), 1, 0);
      C_JR:
        push(o, f, z, 1'b1, pk(0,0,0,0,1,2'd3,0,2'd0,2'd0,0,0,3'd0,0,0), 1, 0);
      default: ;
    endcase
  endtask

  // Drive and check every queued cycle; entered and left on a falling edge.
  task automatic run_queue();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      op = c.op; func = c.func; zero = c.zero; mem_ready = c.rdy;
      #2;
      chk("outputs", 32'(act), 32'(c.exp));
      chk("retired", retired, mret);
      chk("bus_err", 32'(bus_err), 32'(merr));
      if (c.ret) mret = mret + 1;
      if (c.err) merr = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    // Reset state: outputs low even with memory claiming ready.
    mem_ready = 1'b1;
    #12;
    chk("rst_outputs", 32'(act), 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    add_instr(6'h00, 6'h21, 0, 0, 0);             // addu
    chk("addu_len", 32'(q.size()), 32'd4);
    run_queue();
    chk("addu_retired", retired, 32'd1);

    add_instr(6'h00, 6'h23, 0, 0, 0);             // subu
    add_instr(6'h00, 6'h25, 0, 0, 0);             // or
    add_instr(6'h0D, 6'h00, 0, 0, 0);             // ori
    add_instr(6'h0F, 6'h00, 0, 0, 0);             // lui
    run_queue();

    add_instr(6'h23, 6'h00, 0, 3, 0);             // lw, 3 memory waits
    chk("lw_len", 32'(q.size()), 32'd8);
    run_queue();
    add_instr(6'h2B, 6'h00, 0, 1, 0);             // sw, 1 wait
    run_queue();

    add_instr(6'h04, 6'h00, 0, 0, 1);             // beq taken
    chk("beq_len", 32'(q.size()), 32'd3);
    add_instr(6'h04, 6'h00, 0, 0, 0);             // beq not taken
    add_instr(6'h03, 6'h00, 0, 0, 0);             // jal
    add_instr(6'h00, 6'h08, 0, 0, 0);             // jr
    add_instr(6'h02, 6'h00, 0, 0, 0);             // j
    run_queue();

    add_instr(6'h00, 6'h00, 0, 0, 0);             // nop
    chk("nop_len", 32'(q.size()), 32'd2);
    add_instr(6'h3F, 6'h00, 0, 0, 0);             // illegal
    run_queue();
    add_instr(6'h34, 6'h00, 0, 0, 0);             // lwrr
`ifdef MULTICYCLE_LWRR_EN
    chk("lwrr_len", 32'(q.size()), 32'd5);
`else
    chk("lwrr_len", 32'(q.size()), 32'd2);
`endif
    run_queue();

    // Ready arriving exactly at the wait limit completes normally.
    add_instr(6'h0D, 6'h00, TIMEOUT, 0, 0);
    add_instr(6'h23, 6'h00, 0, TIMEOUT, 0);
    run_queue();
    chk("seq_retired", retired, 32'd17);
    chk("seq_no_err", 32'(bus_err), 32'd0);

    // Reset in the middle of a stalled MEM access drops mem_req at once.
    add_instr(6'h23, 6'h00, 0, 2, 0);
    void'(q.pop_back()); void'(q.pop_back()); void'(q.pop_back());
    run_queue();
    mem_ready = 1'b0;
    #1;
    chk("midmem_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midmem_rst_outputs", 32'(act), 32'd0);
    chk("midmem_rst_retired", retired, 32'd0);
    mret = '0; merr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Fetch never answered: TIMEOUT waits, then the error cycle, then HALT.
    for (int i = 0; i < TIMEOUT; i++)
      push(6'h00, 6'h00, 0, 1'b0, pk(1,0,0,0,0,2'd0,0,2'd0,2'd0,0,0,3'd0,0,0), 0, 0);
    push(6'h00, 6'h00, 0, 1'b0, pk(1,0,0,0,0,2'd0,0,2'd0,2'd0,0,0,3'd0,0,0), 0, 1);
    for (int i = 0; i < 3; i++)
      push(6'h00, 6'h21, 0, 1'b1, 19'd0, 0, 0);
    run_queue();
    chk("halt_bus_err", 32'(bus_err), 32'd1);
    chk("halt_mem_req", 32'(mem_req), 32'd0);

    rst_n = 1'b0;
    #1;
    chk("halt_rst_bus_err", 32'(bus_err), 32'd0);
    chk("halt_rst_retired", retired, 32'd0);
    mret = '0; merr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    add_instr(6'h00, 6'h21, 0, 0, 0);
    run_queue();
    chk("post_halt_retired", retired, 32'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit for the MIPS subset datapath: addu, subu, or, ori, lui, lw, sw, beq, j, jal, jr, nop, plus optional lwrr. It replaces the single-cycle combinational decoder with a state machine that sequences fetch, decode, execute, memory and write-back over several cycles. It handshakes with a shared instruction/data memory that may stall, times out stuck accesses, and counts retired instructions. It sits between the IR/ALU-zero flag and every datapath enable and mux select.

## Interface

- `ALUCTL_W`, 3: alu_ctl width, at least 3. Codes: 0 add, 1 sub, 3 or, 4 lui; upper bits 0.
- `TIMEOUT`, 15: maximum wait cycles per memory access before bus error, 1..255.
- `CNT_W`, 32: width of the retired-instruction counter.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `op` in 6: IR[31:26]; valid from DECODE onward.
- `func` in 6: IR[5:0].
- `zero` in 1: ALU equality flag, sampled in BRANCH.
- `mem_ready` in 1: memory completes the request in this cycle.
- `mem_req` out 1: memory request, held until completion.
- `mem_we` out 1: write request; valid while mem_req.
- `i_or_d` out 1: address select, 0 PC, 1 ALU result.
- `ir_we` out 1: IR load strobe.
- `pc_we` out 1: PC write strobe.
- `pc_src` out 2: next-PC select, 0 PC+4, 1 branch target, 2 jump target, 3 rs.
- `reg_we` out 1: register file write.
- `reg_dst` out 2: destination select, 0 rt, 1 rd, 2 $31.
- `wd_sel` out 2: write-data select, 0 ALU out, 1 MDR, 2 PC+4.
- `alu_src_b` out 1: ALU B operand, 0 rt, 1 extended immediate.
- `sign_ext` out 1: immediate extension, 1 sign, 0 zero.
- `alu_ctl` out ALUCTL_W: ALU operation.
- `lwrr` out 1: high while an lwrr instruction is in flight; low when LWRR_EN is off.
- `illegal` out 1: 1-cycle pulse in DECODE for an unrecognised encoding.
- `bus_err` out 1: sticky; set on timeout.
- `retired` out CNT_W: count of completed instructions.

## Operation

- States, 4-bit encoding: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB_ALU 4, WB_MEM 5, BRANCH 6, JUMP 7, HALT 8.
- FETCH: mem_req=1, i_or_d=0, mem_we=0.
  - When mem_ready=1: ir_we=1, pc_we=1, pc_src=0, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: next state by instruction class.
  - R-ALU (addu/subu/or), ori, lui, lw, sw, lwrr go to EXEC.
  - beq goes to BRANCH.
  - j, jal, jr go to JUMP.
  - nop and illegal go to FETCH and count as retired; illegal pulses `illegal`.
- EXEC: computes the ALU result.
  - Loads and stores: alu_ctl=add, alu_src_b=1, sign_ext=1, then MEM.
  - R-ALU: alu_src_b=0, then WB_ALU.
  - ori: alu_src_b=1, sign_ext=0, then WB_ALU.
  - lui: alu_src_b=1, then WB_ALU.
- MEM: mem_req=1, i_or_d=1, mem_we=1 for sw.
  - On mem_ready, lw/lwrr go to WB_MEM.
  - On mem_ready, sw goes to FETCH and retires.
- WB_ALU: reg_we=1, wd_sel=0; reg_dst=1 for R-ALU, 0 for ori/lui; then FETCH.
- WB_MEM: reg_we=1, wd_sel=1, reg_dst=0; then FETCH.
- BRANCH: alu_ctl=sub, alu_src_b=0; pc_we=zero, pc_src=1; then FETCH.
- JUMP: pc_we=1.
  - pc_src=2 for j/jal, 3 for jr.
  - jal also drives reg_we=1, reg_dst=2, wd_sel=2.
  - Then FETCH.
- Any output not listed for a state is 0. alu_ctl defaults to add.
- Retire rule: `retired` increments by 1 on every transition into FETCH from any state other than FETCH. It wraps modulo 2^CNT_W.
- Timeout rule:
  - A wait counter clears on entry to FETCH or MEM and increments each cycle with mem_req=1 and mem_ready=0.
  - When it reaches TIMEOUT with mem_ready still 0, bus_err is set and the state goes to HALT.
  - mem_ready in the same cycle as the limit wins: normal completion, no error.
- HALT: all strobes 0, no requests; left only by reset.

## Timing

- Reset (rst_n=0, asynchronous):
  - state=FETCH, retired=0, bus_err=0, wait counter=0.
  - All outputs 0 while rst_n=0, including mem_req.
- The first mem_req appears in the first cycle after rst_n deasserts.
- Reset asserted mid-MEM drops mem_req immediately; the memory must abandon the access.
- Strobes are Moore outputs of state, except ir_we, pc_we in FETCH and pc_we in BRANCH, which are combinational on mem_ready / zero in the same cycle.
- Latency with zero-wait memory:
  - R-ALU/ori/lui: 4 cycles.
  - lw/lwrr: 5 cycles.
  - sw: 4 cycles.
  - beq, j, jal, jr: 3 cycles.
  - nop/illegal: 2 cycles.
- Each memory wait cycle adds 1 cycle.

## Configuration

- `MULTICYCLE_LWRR_EN` defined:
  - op 6'b110100 decodes as lwrr and follows the lw path (EXEC, MEM, WB_MEM, reg_dst=0).
  - `lwrr` is high from DECODE through WB_MEM.
- Undefined: op 6'b110100 is illegal and `lwrr` is tied 0.

## Test plan

- addu (op 0, func 0x21), mem_ready always 1 → states 0,1,2,4,0; reg_we=1 and reg_dst=1 only in cycle 4; retired 0→1.
- lw with mem_ready low for 3 cycles in MEM → 8 cycles total; WB_MEM has reg_we=1, wd_sel=1; no bus_err.
- beq with zero=1 and then zero=0 → pc_we=1 and pc_src=1 in BRANCH only for the first; both take 3 cycles.
- jal → JUMP drives pc_src=2, reg_dst=2, wd_sel=2, reg_we=1; jr → pc_src=3, reg_we=0.
- TIMEOUT=4 with mem_ready held 0 in FETCH → bus_err=1 after 4 wait cycles, state HALT, mem_req=0 thereafter; rst_n pulse → state FETCH, bus_err=0, retired=0.
- op 6'b110100 → with macro: 5-cycle lw path with lwrr=1; without macro: illegal pulse in DECODE, 2 cycles, retired+1.
